dezigzag: RTL

DEZIGZAG -- requirements
Module: dezigzag

---
 rtl/dezigzag.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dezigzag.sv
// dezigzag: reorders 8x8 coefficient blocks from JPEG zigzag order to raster
// order through a ping-pong pair of 64-entry banks.
// Optional feature macro: DEZIGZAG_ABORT_CNT_EN adds the abort_cnt output.
module dezigzag #(
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] din,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dout,
    output logic          out_sof,
    output logic          out_eob
`ifdef DEZIGZAG_ABORT_CNT_EN
    ,
    output logic [7:0]    abort_cnt
`endif
);

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 2 * (1 << AW);

    // Zigzag index -> raster address (standard JPEG scan).
    localparam logic [AW-1:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic { W_HUNT, W_FILL }    wstate_t;
    typedef enum logic { R_EMPTY, R_STREAM } rstate_t;

    wstate_t       wstate;
    rstate_t       rstate;
    logic [AW-1:0] wcnt;
    logic [AW:0]   rcnt;
    logic [1:0]    full;
    logic          wsel;
    logic          rsel;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          pop;
    logic          load;
    logic          we;
    logic [AW-1:0] wr_idx;
    logic          set_full;
    logic          clr_full;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;

    // Handshake qualifiers and write-side addressing.
    assign in_ready = ~full[wsel];
    assign accept   = in_valid & in_ready & ena;
    assign pop      = out_valid & out_ready & ena;
    assign load     = ena & (rstate == R_STREAM) & ~rcnt[AW] & (~out_valid | out_ready);
    assign wr_idx   = (wstate == W_FILL && !in_sof) ? wcnt : '0;
    assign we       = accept & (in_sof | (wstate == W_FILL));
    assign set_full = we & (wr_idx == 6'd63);
    assign clr_full = pop & out_eob;
    assign set_mask = {set_full & wsel, set_full & ~wsel};
    assign clr_mask = {clr_full & rsel, clr_full & ~rsel};

    // Coefficient storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wsel, ZZ[wr_idx]}] <= din;
        end
    end

    // Write FSM, bank flags, read FSM and registered output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate    <= W_HUNT;
            rstate    <= R_EMPTY;
            wcnt      <= '0;
            rcnt      <= '0;
            full      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eob   <= 1'b0;
            dout      <= '0;
        end else if (ena) begin
            full <= (full & ~clr_mask) | set_mask;

            case (wstate)
                W_HUNT: begin
                    if (accept && in_sof) begin
                        wcnt   <= 6'd1;
                        wstate <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (accept) begin
                        if (in_sof) begin
                            wcnt <= 6'd1;
                        end else if (wcnt == 6'd63) begin
                            wcnt   <= '0;
                            wsel   <= ~wsel;
                            wstate <= W_HUNT;
                        end else begin
                            wcnt <= wcnt + 6'd1;
                        end
                    end
                end
                default: wstate <= W_HUNT;
            endcase

            case (rstate)
                R_EMPTY: begin
                    if (full[rsel]) begin
                        rcnt   <= '0;
                        rstate <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (clr_full) begin
                        rcnt   <= '0;
                        rsel   <= ~rsel;
                        rstate <= R_EMPTY;
                    end else if (load) begin
                        rcnt <= rcnt + 7'd1;
                    end
                end
                default: rstate <= R_EMPTY;
            endcase

            if (load) begin
                out_valid <= 1'b1;
                dout      <= mem[{rsel, rcnt[AW-1:0]}];
                out_sof   <= (rcnt == 7'd0);
                out_eob   <= (rcnt == 7'd63);
            end else if (pop) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eob   <= 1'b0;
            end
        end
    end

`ifdef DEZIGZAG_ABORT_CNT_EN
    // Counts blocks abandoned by a fresh in_sof, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_cnt <= '0;
        end else if (accept && wstate == W_FILL && in_sof && abort_cnt != 8'd255) begin
            abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule
